ddr2_line_bridge: RTL and testbench

DDR2_LINE_BRIDGE -- requirements
Module: ddr2_line_bridge

---
 rtl/ddr2_line_bridge.sv | 167 ++++++++++++++++
 tb/tb_ddr2_line_bridge.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_line_bridge.sv
// Bridges 128-bit cache line requests onto a DDR2 MIG-style app interface.
// Requests are queued in order and issued one at a time; reads return a one-cycle response pulse.
module ddr2_line_bridge #(
  parameter int QDEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [26:0]  req_addr,
  input  logic [127:0] req_wdata,
  input  logic         req_en,
  input  logic         req_read,
  output logic [127:0] resp_data,
  output logic         resp_valid,
  output logic         busy,
  output logic         ovf_err,
  input  logic         init_calib_complete,
  output logic [26:0]  app_addr,
  output logic [2:0]   app_cmd,
  output logic         app_en,
  input  logic         app_rdy,
  output logic [127:0] app_wdf_data,
  output logic         app_wdf_wren,
  output logic         app_wdf_end,
  output logic [15:0]  app_wdf_mask,
  input  logic         app_wdf_rdy,
  input  logic [127:0] app_rd_data,
  input  logic         app_rd_data_valid
);

  localparam int PW = $clog2(QDEPTH);

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_CMD, RD_CMD, RD_WAIT} state_t;

  state_t       r_state;
  logic [22:0]  r_qAddr [QDEPTH];
  logic [127:0] r_qData [QDEPTH];
  logic         r_qRead [QDEPTH];
  logic [PW:0]  r_wrPtr;
  logic [PW:0]  r_rdPtr;
  logic         r_ovfErr;
  logic [127:0] r_respData;
  logic         r_respValid;
  logic [26:0]  r_appAddr;
  logic [2:0]   r_appCmd;
  logic         r_appEn;
  logic [127:0] r_wdfData;
  logic         r_wdfWren;
  logic         r_wdfEnd;

  logic         w_empty;
  logic         w_full;
  logic         w_pop;
  logic         w_push;
  logic [22:0]  w_headAddr;
  logic [127:0] w_headData;
  logic         w_headRead;
  logic         w_unusedAddrBits;

  // Line-aligned addressing: the byte offset inside the line is never needed.
  assign w_unusedAddrBits = ^req_addr[3:0];

  assign w_empty    = (r_wrPtr == r_rdPtr);
  assign w_full     = (r_wrPtr[PW] != r_rdPtr[PW]) &&
                      (r_wrPtr[PW-1:0] == r_rdPtr[PW-1:0]);
  assign w_pop      = (r_state == IDLE) && !w_empty && init_calib_complete;
  // A full queue still accepts a request in the cycle its head is popped.
  assign w_push     = req_en && (!w_full || w_pop);
  assign w_headAddr = r_qAddr[r_rdPtr[PW-1:0]];
  assign w_headData = r_qData[r_rdPtr[PW-1:0]];
  assign w_headRead = r_qRead[r_rdPtr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_qAddr[r_wrPtr[PW-1:0]] <= req_addr[26:4];
      r_qData[r_wrPtr[PW-1:0]] <= req_wdata;
      r_qRead[r_wrPtr[PW-1:0]] <= req_read;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_ovfErr <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
      if (req_en && !w_push) r_ovfErr <= 1'b1;
    end
  end

  // Issue FSM; every app-side output is a register so it stays stable while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_respData  <= '0;
      r_respValid <= 1'b0;
      r_appAddr   <= '0;
      r_appCmd    <= 3'b000;
      r_appEn     <= 1'b0;
      r_wdfData   <= '0;
      r_wdfWren   <= 1'b0;
      r_wdfEnd    <= 1'b0;
    end else begin
      r_respValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_appAddr <= {w_headAddr, 4'b0000};
            if (w_headRead) begin
              r_state  <= RD_CMD;
              r_appEn  <= 1'b1;
              r_appCmd <= 3'b001;
            end else begin
              r_state   <= WR_DATA;
              r_wdfWren <= 1'b1;
              r_wdfEnd  <= 1'b1;
              r_wdfData <= w_headData;
            end
          end
        end
        WR_DATA: begin
          if (app_wdf_rdy) begin
            r_state   <= WR_CMD;
            r_wdfWren <= 1'b0;
            r_wdfEnd  <= 1'b0;
            r_appEn   <= 1'b1;
            r_appCmd  <= 3'b000;
          end
        end
        WR_CMD: begin
          if (app_rdy) begin
            r_state <= IDLE;
            r_appEn <= 1'b0;
          end
        end
        RD_CMD: begin
          if (app_rdy) begin
            r_state <= RD_WAIT;
            r_appEn <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (app_rd_data_valid) begin
            r_state     <= IDLE;
            r_respData  <= app_rd_data;
            r_respValid <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_data    = r_respData;
  assign resp_valid   = r_respValid;
  assign busy         = !w_empty || (r_state != IDLE);
  assign ovf_err      = r_ovfErr;
  assign app_addr     = r_appAddr;
  assign app_cmd      = r_appCmd;
  assign app_en       = r_appEn;
  assign app_wdf_data = r_wdfData;
  assign app_wdf_wren = r_wdfWren;
  assign app_wdf_end  = r_wdfEnd;
  assign app_wdf_mask = 16'h0000;

endmodule

// File: tb/tb_ddr2_line_bridge.sv
// Self-checking bench for ddr2_line_bridge: an in-order transaction model plus a
// simple memory responder, with directed scenarios and literal spot checks.
module tb_ddr2_line_bridge;

  logic         clk = 1'b0;
  logic         rstn;
  logic [26:0]  req_addr;
  logic [127:0] req_wdata;
  logic         req_en;
  logic         req_read;
  logic [127:0] resp_data;
  logic         resp_valid;
  logic         busy;
  logic         ovf_err;
  logic         init_calib_complete;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;

  ddr2_line_bridge #(.QDEPTH(4)) dut (
    .clk(clk), .rstn(rstn),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_en(req_en), .req_read(req_read),
    .resp_data(resp_data), .resp_valid(resp_valid), .busy(busy), .ovf_err(ovf_err),
    .init_calib_complete(init_calib_complete),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         isRead;
    logic [26:0]  addr;
    logic [127:0] data;
  } cmd_t;

  cmd_t         expCmd[$];
  logic [127:0] expResp[$];
  logic         expOvf = 1'b0;
  int           errors = 0;
  int           checks = 0;
  int           cycle = 0;
  int           reqCycle = 0;
  int           respCycle = 0;
  int           respCount = 0;
  int           rdDelay = 1;
  int           spurReq = 0;
  logic [26:0]  lastCmdAddr = '0;
  logic         prevRespValid = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  // Memory contents seen by the bench: one recognisable line, the rest derived from the address.
  function automatic logic [127:0] lineData(input logic [26:0] a);
    if (a == 27'h0001230) return {16{8'hA5}};
    return {4{5'b00000, a}};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: event occurred, none expected", name);
  endtask

  // One request per call; back-to-back calls give consecutive req_en cycles.
  task automatic applyStimulus(input logic [26:0] addr, input logic [127:0] data,
                               input logic isRead, input logic expectAccept);
    cmd_t c;
    req_addr  = addr;
    req_wdata = data;
    req_read  = isRead;
    req_en    = 1'b1;
    reqCycle  = cycle;
    @(posedge clk);
    #1;
    req_en = 1'b0;
    if (expectAccept) begin
      c.isRead = isRead;
      c.addr   = {addr[26:4], 4'b0000};
      c.data   = data;
      expCmd.push_back(c);
      if (isRead) expResp.push_back(lineData(c.addr));
    end else begin
      expOvf = 1'b1;
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_resp_data", resp_data, 0);
    checkOutput("rst_app_en", app_en, 0);
    checkOutput("rst_wdf_wren", app_wdf_wren, 0);
    checkOutput("rst_wdf_end", app_wdf_end, 0);
    checkOutput("rst_app_addr", app_addr, 0);
    checkOutput("rst_app_cmd", app_cmd, 0);
    checkOutput("rst_wdf_data", app_wdf_data, 0);
    checkOutput("rst_wdf_mask", app_wdf_mask, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ovf_err", ovf_err, 0);
  endtask

  task automatic resetDut(input int holdCycles);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    checkResetValues();
    expCmd.delete();
    expResp.delete();
    expOvf = 1'b0;
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkOutput("rst_hold_resp_valid", resp_valid, 0);
      checkOutput("rst_hold_app_en", app_en, 0);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic waitIdle(input int maxCycles);
    logic done;
    done = 1'b0;
    for (int i = 0; i < maxCycles && !done; i++) begin
      @(negedge clk);
      if (expCmd.size() == 0 && expResp.size() == 0 && !busy) done = 1'b1;
    end
    checkOutput("drain_within_budget", done, 1);
    @(posedge clk);
    #1;
  endtask

  // Compare process: every handshake and response is matched against the in-order model.
  always @(negedge clk) begin
    cmd_t h;
    if (rstn) begin
      checkOutput("wdf_mask", app_wdf_mask, 0);
      if (!init_calib_complete) checkOutput("no_issue_uncalibrated", {app_en, app_wdf_wren}, 0);
      if (app_wdf_wren && app_wdf_rdy) begin
        if (expCmd.size() == 0) failNow("unexpected_wdf");
        else begin
          checkOutput("wdf_head_is_write", expCmd[0].isRead, 0);
          checkOutput("wdf_data", app_wdf_data, expCmd[0].data);
          checkOutput("wdf_end", app_wdf_end, 1);
        end
      end
      if (app_en && app_rdy) begin
        if (expCmd.size() == 0) failNow("unexpected_cmd");
        else begin
          h = expCmd.pop_front();
          checkOutput("cmd_code", app_cmd, h.isRead ? 3'b001 : 3'b000);
          checkOutput("cmd_addr", app_addr, h.addr);
          lastCmdAddr = app_addr;
        end
      end
      if (resp_valid) begin
        respCount++;
        respCycle = cycle;
        checkOutput("resp_single_cycle", prevRespValid, 0);
        if (expResp.size() == 0) failNow("unexpected_resp");
        else checkOutput("resp_data", resp_data, expResp.pop_front());
      end
      checkOutput("ovf_err", ovf_err, expOvf);
      prevRespValid = resp_valid;
    end else begin
      prevRespValid = 1'b0;
    end
  end

  // Memory responder: returns line data rdDelay cycles after a read command is accepted.
  initial begin
    logic [26:0] a;
    int spurDone;
    spurDone = 0;
    app_rd_data_valid = 1'b0;
    app_rd_data = '0;
    forever begin
      @(negedge clk);
      if (rstn && app_en && app_rdy && app_cmd == 3'b001) begin
        a = app_addr;
        @(posedge clk);
        repeat (rdDelay - 1) @(posedge clk);
        #1;
        app_rd_data_valid = 1'b1;
        app_rd_data = lineData(a);
        @(posedge clk);
        #1;
        app_rd_data_valid = 1'b0;
        app_rd_data = '0;
      end else if (spurReq != spurDone) begin
        spurDone = spurReq;
        @(posedge clk);
        #1;
        app_rd_data_valid = 1'b1;
        app_rd_data = {4{32'hFFFF_0000}};
        @(posedge clk);
        #1;
        app_rd_data_valid = 1'b0;
        app_rd_data = '0;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt0;
    rstn = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_en = 1'b0;
    req_read = 1'b0;
    init_calib_complete = 1'b1;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    #2;
    checkResetValues();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Single read at minimum latency.
    applyStimulus(27'h0001230, '0, 1'b1, 1'b1);
    waitIdle(20);
    checkOutput("t1_cmd_addr_literal", lastCmdAddr, 27'h0001230);
    checkOutput("t1_resp_data_literal", resp_data, {16{8'hA5}});
    checkOutput("t1_latency", respCycle - reqCycle, 4);
    checkOutput("t1_resp_count", respCount, 1);

    // Read data valid while idle must be ignored.
    spurReq++;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("spurious_no_resp", respCount, 1);
    checkOutput("spurious_data_kept", resp_data, {16{8'hA5}});

    // Dirty eviction: write then read on consecutive cycles; unaligned write address.
    cnt0 = respCount;
    applyStimulus(27'h0004567, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 1'b0, 1'b1);
    applyStimulus(27'h0001230, '0, 1'b1, 1'b1);
    waitIdle(40);
    checkOutput("t2_one_resp", respCount - cnt0, 1);

    // Held off by calibration, then issued in order; highest line address.
    init_calib_complete = 1'b0;
    applyStimulus(27'h0000100, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, 1'b1);
    applyStimulus(27'h7FFFFFF, '0, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t3_busy_while_held", busy, 1);
    checkOutput("t3_nothing_issued", expCmd.size(), 2);
    init_calib_complete = 1'b1;
    waitIdle(40);

    // Backpressure on both write data and command channels.
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    applyStimulus(27'h0002220, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("t4_wren_held", {app_wdf_wren, app_wdf_end, app_en}, 3'b110);
      checkOutput("t4_wdata_held", app_wdf_data, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    end
    @(posedge clk);
    #1 app_wdf_rdy = 1'b1;
    @(posedge clk);
    #1 app_wdf_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("t4_en_held", {app_en, app_wdf_wren}, 2'b10);
      checkOutput("t4_addr_held", app_addr, 27'h0002220);
      checkOutput("t4_cmd_held", app_cmd, 3'b000);
    end
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    waitIdle(20);
    checkOutput("t4_resp_data_kept", resp_data, lineData(27'h7FFFFF0));

    // Overflow: fifth push on a full, stalled queue is lost.
    init_calib_complete = 1'b0;
    applyStimulus(27'h0010000, 128'hA1, 1'b0, 1'b1);
    applyStimulus(27'h0010010, '0, 1'b1, 1'b1);
    applyStimulus(27'h0010020, 128'hA3, 1'b0, 1'b1);
    applyStimulus(27'h0010030, '0, 1'b1, 1'b1);
    applyStimulus(27'h0010040, 128'hA5, 1'b0, 1'b0);
    checkOutput("t5_ovf_set", ovf_err, 1);
    init_calib_complete = 1'b1;
    waitIdle(80);
    checkOutput("t5_ovf_sticky", ovf_err, 1);
    resetDut(1);
    checkOutput("t5_ovf_cleared", ovf_err, 0);

    // Full queue: push in the same cycle as a pop is accepted.
    init_calib_complete = 1'b0;
    applyStimulus(27'h0020000, 128'hB1, 1'b0, 1'b1);
    applyStimulus(27'h0020010, '0, 1'b1, 1'b1);
    applyStimulus(27'h0020020, '0, 1'b1, 1'b1);
    applyStimulus(27'h0020030, 128'hB4, 1'b0, 1'b1);
    init_calib_complete = 1'b1;
    applyStimulus(27'h0020040, '0, 1'b1, 1'b1);
    waitIdle(80);
    checkOutput("t5b_no_ovf", ovf_err, 0);

    // Reset while waiting for read data: no response, ever.
    cnt0 = respCount;
    rdDelay = 6;
    applyStimulus(27'h0003330, '0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    resetDut(8);
    checkOutput("t6_no_resp", respCount - cnt0, 0);
    rdDelay = 1;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues();

    // First request after reset is handled normally.
    applyStimulus(27'h0005550, '0, 1'b1, 1'b1);
    waitIdle(20);
    checkOutput("t7_one_resp", respCount - cnt0, 1);
    checkOutput("t7_resp_data", resp_data, lineData(27'h0005550));

    checkOutput("model_drained", expCmd.size() + expResp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
